reg_bank_dma: RTL and testbench
===============================

// Module: reg_bank_dma
// PURPOSE
//  Parametrised bank of DEPTH registers, WIDTH bits each; successor to the single 32-bit data register.
//  Provides one byte-enabled write port and two independent registered read ports (A, B).
//  Adds a sequential dump engine that streams every register out over a valid/ready channel to the DMA path.
//  Sits between the datapath, which writes and reads it, and the DMA/protocol blocks, which consume the dump stream.
// PARAMETERS
//  WIDTH  32  register width in bits; must be a multiple of 8
//  DEPTH  8   number of registers; >=2, need not be a power of 2
//  AW     $clog2(DEPTH)  derived localparam, address width; not overridable
// PORTS
//  clk         in   1         single clock; all logic on its rising edge
//  rst_n       in   1         reset, synchronous, active-low
//  wr_en       in   1         write strobe
//  wr_addr     in   AW        write register index
//  wr_data     in   WIDTH     write data
//  wr_be       in   WIDTH/8   byte-lane enables; bit i covers data bits [8i+7:8i]
//  rd_en_a     in   1         port A read request
//  rd_addr_a   in   AW        port A register index
//  rd_data_a   out  WIDTH     port A read data
//  rd_valid_a  out  1         port A data valid, one-cycle pulse
//  rd_en_b / rd_addr_b / rd_data_b / rd_valid_b   same as port A
//  dump_start  in   1         request a full-bank dump
//  dump_busy   out  1         dump in progress
//  dump_valid  out  1         dump beat presented
//  dump_ready  in   1         consumer accepts beat
//  dump_addr   out  AW        index of presented beat
//  dump_data   out  WIDTH     value of presented beat
//  dump_done   out  1         one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): all registers=0; all outputs=0; FSM=IDLE. Reset overrides every other input, including mid-dump.
//  Write: wr_en=1 -> lanes with wr_be[i]=1 updated at the edge; other lanes hold. wr_addr>=DEPTH -> write ignored.
//  Read latency: 1 cycle. rd_en_x=1 in cycle N -> rd_data_x/rd_valid_x=1 in cycle N+1.
//  rd_valid_x is low when rd_en_x was low; rd_data_x holds its last value.
//  Write-first bypass: a read in the same cycle as a write to the same index returns the byte-merged new value.
//  A/B may read the same or different indices in the same cycle. rd_addr>=DEPTH -> data 0, valid still 1.
//  Dump FSM: IDLE -> SEND -> DONE -> IDLE.
//   IDLE: dump_start=1 -> SEND; ptr=0; load beat 0 (with write bypass). dump_busy=1 from the next cycle.
//   SEND: dump_valid=1. dump_addr/dump_data stay stable while dump_ready=0; later writes to that index do not alter the held beat.
//   SEND, valid&&ready: if ptr==DEPTH-1 -> DONE. Otherwise ptr+1 and load the next beat in the same edge (with bypass). Throughput is 1 beat per cycle.
//   DONE: dump_valid=0; dump_done=1 for one cycle; dump_busy=0 from the following cycle; -> IDLE.
//   dump_start is ignored outside IDLE. The dump never blocks the write or read ports.
//  Simultaneous write plus two reads plus a dump beat to the same index -> every consumer sees the merged new value.
// STRUCTURE
//  Package reg_bank_pkg: dump state enum (IDLE/SEND/DONE) and a byte-merge function merge_be(old,new,be), shared by the bypass paths.
//  Sub-module reg_bank_dump_fsm: pointer, state and beat holding register. It reads the bank through an index/data pair with bypass applied in the parent.
//  Parent holds the storage array, the write decode and both read ports.
// TESTING
//  1. Reset, then read all indices on A and B -> data 0, valid pulses one cycle after each request.
//  2. WIDTH=32: write 0xAABBCCDD to idx 3 with be=4'b1111, then 0x11223344 with be=4'b0101 -> A reads 0xAA22CC44.
//  3. Same cycle: write 0xDEADBEEF to idx 5 (be all set) and read 5 on A and B -> both return 0xDEADBEEF next cycle.
//  4. DEPTH=8, registers preloaded as idx*0x10, dump_ready held 1 -> 8 beats, addr 0..7 on consecutive cycles, data 0x00..0x70, then dump_done pulse.
//  5. Dump with dump_ready toggling 1-0-0-1 and a write to the presented index while stalled -> beat held stable; later beats correct; dump_start mid-dump ignored.
//  6. rst_n=0 on beat 4 of a dump -> next cycle valid/busy/done=0 and bank cleared; a fresh dump_start restarts at addr 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared types and helpers for the register bank with dump
//               engine: dump FSM state encoding and the byte-lane merge used
//               by the write path and every bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    // Widest register the merge helper supports; callers cast in and out.
    localparam int MERGE_W  = 1024;
    localparam int MERGE_BE = MERGE_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

    // Byte-lane merge: lanes with be set take new_val, others keep old_val.
    function automatic logic [MERGE_W-1:0] merge_be(
        input logic [MERGE_W-1:0]  old_val,
        input logic [MERGE_W-1:0]  new_val,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_W-1:0] res;
        for (int i = 0; i < MERGE_BE; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_dma_dump_fsm.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_dump_fsm
// Description : Sequential dump engine. Walks the bank from index 0 to
//               DEPTH-1, holding each beat in a local register so the
//               presented data stays stable while the consumer stalls.
//               The parent supplies bank data (with write bypass) for rd_idx.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_dump_fsm
    import reg_bank_pkg::*;
#(
    parameter int   WIDTH = 32,
    parameter int   DEPTH = 8,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dump_start,
    input  logic             dump_ready,
    output logic [AW-1:0]    rd_idx,
    input  logic [WIDTH-1:0] rd_data,
    output logic             dump_busy,
    output logic             dump_valid,
    output logic [AW-1:0]    dump_addr,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_done
);

    localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

    dump_state_t      r_state;
    dump_state_t      w_state_nx;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_nx;
    logic [WIDTH-1:0] r_beat;
    logic [WIDTH-1:0] w_beat_nx;

    // State, pointer and held beat registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_beat  <= w_beat_nx;
        end
    end

    // Next state: the beat is only reloaded on start or on an accepted beat
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_beat_nx  = r_beat;
        rd_idx     = '0;
        case (r_state)
            ST_IDLE: begin
                rd_idx = '0;
                if (dump_start) begin
                    w_state_nx = ST_SEND;
                    w_ptr_nx   = '0;
                    w_beat_nx  = rd_data;
                end
            end
            ST_SEND: begin
                rd_idx = r_ptr + AW'(1);
                if (dump_ready) begin
                    if (r_ptr == c_last) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_ptr_nx  = r_ptr + AW'(1);
                        w_beat_nx = rd_data;
                    end
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; address/data come straight from registers
    always_comb begin
        dump_valid = (r_state == ST_SEND);
        dump_busy  = (r_state != ST_IDLE);
        dump_done  = (r_state == ST_DONE);
        dump_addr  = r_ptr;
        dump_data  = r_beat;
    end

endmodule
`default_nettype wire

// File: rtl/reg_bank_dma.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_dma
// Description : DEPTH x WIDTH register bank with one byte-enabled write
//               port, two registered read ports and a valid/ready dump
//               stream. All readers see same-cycle writes (write-first).
//               WIDTH must be a multiple of 8 and no wider than MERGE_W.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_dma
    import reg_bank_pkg::*;
#(
    parameter int   WIDTH = 32,
    parameter int   DEPTH = 8,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic               rd_en_a,
    input  logic [AW-1:0]      rd_addr_a,
    output logic [WIDTH-1:0]   rd_data_a,
    output logic               rd_valid_a,
    input  logic               rd_en_b,
    input  logic [AW-1:0]      rd_addr_b,
    output logic [WIDTH-1:0]   rd_data_b,
    output logic               rd_valid_b,
    input  logic               dump_start,
    output logic               dump_busy,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [AW-1:0]      dump_addr,
    output logic [WIDTH-1:0]   dump_data,
    output logic               dump_done
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_bank [DEPTH];
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_wr_merged;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [AW-1:0]    w_dump_idx;
    logic [WIDTH-1:0] w_dump_rd;

    // Out-of-range indices only exist when DEPTH is not a power of two
    assign w_wr_ok     = wr_en && ({1'b0, wr_addr} < c_depth);
    assign w_wr_merged = WIDTH'(merge_be(MERGE_W'(r_bank[wr_addr]),
                                         MERGE_W'(wr_data),
                                         MERGE_BE'(wr_be)));

    // Bank lookup with write-first bypass; out-of-range reads return zero
    function automatic logic [WIDTH-1:0] bank_read(input logic [AW-1:0] idx);
        logic [WIDTH-1:0] v;
        v = '0;
        if ({1'b0, idx} < c_depth) begin
            if (w_wr_ok && (idx == wr_addr)) begin
                v = w_wr_merged;
            end else begin
                v = r_bank[idx];
            end
        end
        return v;
    endfunction

    assign w_rd_a    = bank_read(rd_addr_a);
    assign w_rd_b    = bank_read(rd_addr_b);
    assign w_dump_rd = bank_read(w_dump_idx);

    // Storage: cleared on reset, byte-lane write otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_bank[wr_addr] <= w_wr_merged;
        end
    end

    // Read ports: one-cycle latency, data holds when no request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) begin
                rd_data_a <= w_rd_a;
            end
            if (rd_en_b) begin
                rd_data_b <= w_rd_b;
            end
        end
    end

    reg_bank_dump_fsm #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dump (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .rd_idx     (w_dump_idx),
        .rd_data    (w_dump_rd),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_dma.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_reg_bank_dma
// Description : Self-checking bench for reg_bank_dma (WIDTH=32, DEPTH=8).
//               Expected read and dump results are queued when stimulus is
//               driven and compared when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_dma;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } dump_exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [31:0]      wr_data = '0;
    logic [3:0]       wr_be = '0;
    logic             rd_en_a = 1'b0;
    logic [AW-1:0]    rd_addr_a = '0;
    logic [31:0]      rd_data_a;
    logic             rd_valid_a;
    logic             rd_en_b = 1'b0;
    logic [AW-1:0]    rd_addr_b = '0;
    logic [31:0]      rd_data_b;
    logic             rd_valid_b;
    logic             dump_start = 1'b0;
    logic             dump_busy;
    logic             dump_valid;
    logic             dump_ready = 1'b0;
    logic [AW-1:0]    dump_addr;
    logic [31:0]      dump_data;
    logic             dump_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          start_cyc = 1000000;
    int          exp_done = -10;
    bit          dump_active = 1'b0;
    logic [31:0] mdl [DEPTH];
    rd_exp_t     qa[$];
    rd_exp_t     qb[$];
    dump_exp_t   dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bank_dma #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        end
        return r;
    endfunction

    // Apply this cycle's stimulus to the model, queue expectations, advance one clock
    task automatic cycle();
        if (rst_n) begin
            if (wr_en) mdl[wr_addr] = model_merge(mdl[wr_addr], wr_data, wr_be);
            if (rd_en_a) qa.push_back('{cyc, mdl[rd_addr_a]});
            if (rd_en_b) qb.push_back('{cyc, mdl[rd_addr_b]});
            if (dump_start && !dump_active) begin
                dump_active = 1'b1;
                start_cyc   = cyc;
                for (int i = 0; i < DEPTH; i++) dq.push_back('{AW'(i), mdl[i]});
            end
        end
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
        rd_en_a    = 1'b0;
        rd_en_b    = 1'b0;
        dump_start = 1'b0;
    endtask

    task automatic wait_dump();
        int n;
        n = 0;
        while (dump_active && n < 100) begin
            cycle();
            n++;
        end
        chk("dump_timeout", {63'd0, dump_active}, 64'd0);
        cycle();
    endtask

    task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = AW'(idx);
        wr_data = d;
        wr_be   = be;
    endtask

    // Output monitor: compares read ports and dump stream against queued expectations
    always @(negedge clk) begin
        if (rst_n) begin
            if (qa.size() > 0 && qa[0].cyc + 1 == cyc) begin
                chk("rd_valid_a", {63'd0, rd_valid_a}, 64'd1);
                chk("rd_data_a", {32'd0, rd_data_a}, {32'd0, qa[0].data});
                void'(qa.pop_front());
            end else if (rd_valid_a) begin
                chk("rd_valid_a_spurious", {63'd0, rd_valid_a}, 64'd0);
            end
            if (qb.size() > 0 && qb[0].cyc + 1 == cyc) begin
                chk("rd_valid_b", {63'd0, rd_valid_b}, 64'd1);
                chk("rd_data_b", {32'd0, rd_data_b}, {32'd0, qb[0].data});
                void'(qb.pop_front());
            end else if (rd_valid_b) begin
                chk("rd_valid_b_spurious", {63'd0, rd_valid_b}, 64'd0);
            end
            if (dump_valid) begin
                if (dq.size() == 0) begin
                    chk("dump_valid_spurious", {63'd0, dump_valid}, 64'd0);
                end else begin
                    chk("dump_addr", {61'd0, dump_addr}, {61'd0, dq[0].addr});
                    chk("dump_data", {32'd0, dump_data}, {32'd0, dq[0].data});
                    chk("dump_busy", {63'd0, dump_busy}, 64'd1);
                    if (dump_ready) begin
                        void'(dq.pop_front());
                        if (dq.size() == 0) exp_done = cyc + 1;
                    end
                end
            end else if (dq.size() > 0 && cyc > start_cyc) begin
                chk("dump_valid_missing", {63'd0, dump_valid}, 64'd1);
            end
            if (dump_done || cyc == exp_done) begin
                chk("dump_done", {63'd0, dump_done}, {63'd0, cyc == exp_done});
                if (cyc == exp_done) begin
                    chk("dump_busy_in_done", {63'd0, dump_busy}, 64'd1);
                    dump_active = 1'b0;
                end
            end
            if (cyc == exp_done + 1) begin
                chk("dump_busy_after_done", {63'd0, dump_busy}, 64'd0);
            end
        end
    end

    // Stimulus sequence
    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        // Reset, then read every index on both ports
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("rst_rd_valid_a", {63'd0, rd_valid_a}, 64'd0);
        chk("rst_rd_valid_b", {63'd0, rd_valid_b}, 64'd0);
        chk("rst_rd_data_a", {32'd0, rd_data_a}, 64'd0);
        chk("rst_rd_data_b", {32'd0, rd_data_b}, 64'd0);
        chk("rst_dump_valid", {63'd0, dump_valid}, 64'd0);
        chk("rst_dump_busy", {63'd0, dump_busy}, 64'd0);
        chk("rst_dump_done", {63'd0, dump_done}, 64'd0);
        chk("rst_dump_data", {32'd0, dump_data}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_en_a = 1'b1; rd_addr_a = AW'(i);
            rd_en_b = 1'b1; rd_addr_b = AW'(DEPTH - 1 - i);
            cycle();
        end
        cycle();

        // Byte-enable merge
        do_write(3, 32'hAABBCCDD, 4'b1111); cycle();
        do_write(3, 32'h11223344, 4'b0101); cycle();
        rd_en_a = 1'b1; rd_addr_a = 3'd3; cycle();
        cycle();
        chk("be_merge_abs", {32'd0, rd_data_a}, 64'h00000000AA22CC44);

        // Same-cycle write and dual read bypass
        do_write(5, 32'hDEADBEEF, 4'b1111);
        rd_en_a = 1'b1; rd_addr_a = 3'd5;
        rd_en_b = 1'b1; rd_addr_b = 3'd5;
        cycle();
        cycle();
        chk("bypass_abs_b", {32'd0, rd_data_b}, 64'h00000000DEADBEEF);

        // Full-speed dump of idx*0x10
        for (int i = 0; i < DEPTH; i++) begin
            do_write(i, 32'(i * 16), 4'b1111);
            cycle();
        end
        dump_ready = 1'b1;
        dump_start = 1'b1;
        cycle();
        wait_dump();

        // Stalled dump: bypass on start, writes to the held beat, ignored restart
        dump_ready = 1'b0;
        do_write(0, 32'h5A5A1234, 4'b1100);
        rd_en_a = 1'b1; rd_addr_a = 3'd0;
        rd_en_b = 1'b1; rd_addr_b = 3'd0;
        dump_start = 1'b1;
        cycle();
        do_write(0, 32'h12345678, 4'b1111);
        dump_start = 1'b1;
        cycle();
        dump_ready = 1'b1; cycle();
        dump_ready = 1'b0;
        do_write(1, 32'hCAFEF00D, 4'b1111);
        cycle();
        cycle();
        dump_ready = 1'b1;
        wait_dump();
        rd_en_a = 1'b1; rd_addr_a = 3'd0;
        rd_en_b = 1'b1; rd_addr_b = 3'd1;
        cycle();
        cycle();

        // Reset in the middle of a dump, then restart from index 0
        dump_ready = 1'b1;
        dump_start = 1'b1;
        cycle();
        begin
            int n;
            n = 0;
            while (dump_addr != 3'd4 && n < 20) begin
                cycle();
                n++;
            end
            chk("reach_beat4", {61'd0, dump_addr}, 64'd4);
        end
        rst_n = 1'b0;
        cycle();
        chk("midrst_dump_valid", {63'd0, dump_valid}, 64'd0);
        chk("midrst_dump_busy", {63'd0, dump_busy}, 64'd0);
        chk("midrst_dump_done", {63'd0, dump_done}, 64'd0);
        dq.delete();
        qa.delete();
        qb.delete();
        dump_active = 1'b0;
        exp_done    = -10;
        start_cyc   = 1000000;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_en_a = 1'b1; rd_addr_a = AW'(i);
            rd_en_b = 1'b1; rd_addr_b = AW'(i);
            cycle();
        end
        dump_start = 1'b1;
        cycle();
        chk("restart_addr0", {61'd0, dump_addr}, 64'd0);
        wait_dump();

        cycle();
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
